// File: rtl/axis_realign_sched_if.sv
// axis_realign_sched_if: command, source-stream, realigner and status signals of the scheduler.
interface axis_realign_sched_if #(parameter int LEN_WIDTH = 16);
    logic [1:0]             req_cmd_valid;
    logic [1:0]             req_cmd_ready;
    logic [3:0]             req_cmd_src_off;
    logic [3:0]             req_cmd_dst_off;
    logic [2*LEN_WIDTH-1:0] req_cmd_len;
    logic [63:0]            req_tdata;
    logic [1:0]             req_tvalid;
    logic [1:0]             req_tready;
    logic                   ra_init;
    logic [1:0]             ra_offset;
    logic [31:0]            ra_tdata;
    logic [3:0]             ra_tkeep;
    logic                   ra_tlast;
    logic                   ra_tvalid;
    logic                   ra_tready;
    logic                   ra_m_tvalid;
    logic                   ra_m_tready;
    logic                   ra_m_tlast;
    logic [1:0]             done;
    logic [1:0]             grant;
    modport master (
        input  req_cmd_valid, req_cmd_src_off, req_cmd_dst_off, req_cmd_len, req_tdata, req_tvalid,
               ra_tready, ra_m_tvalid, ra_m_tready, ra_m_tlast,
        output req_cmd_ready, req_tready, ra_init, ra_offset, ra_tdata, ra_tkeep, ra_tlast, ra_tvalid,
               done, grant
    );
    modport slave (
        output req_cmd_valid, req_cmd_src_off, req_cmd_dst_off, req_cmd_len, req_tdata, req_tvalid,
               ra_tready, ra_m_tvalid, ra_m_tready, ra_m_tlast,
        input  req_cmd_ready, req_tready, ra_init, ra_offset, ra_tdata, ra_tkeep, ra_tlast, ra_tvalid,
               done, grant
    );
endinterface

// File: rtl/axis_realign_sched.sv
// axis_realign_sched: round-robin sharing of one axis_realign datapath between two requesters,
// generating per-beat tkeep/tlast from source offset and byte length.
module axis_realign_sched #(parameter int LEN_WIDTH = 16) (
    input logic                  aclk,
    input logic                  aresetn,
    axis_realign_sched_if.master io_bus
);
    typedef enum logic [1:0] {IDLE, INIT, XFER, DRAIN} state_t;
    state_t               r_state, w_next;
    logic                 r_last, r_sel, r_first, r_flag;
    logic [1:0]           r_src_off, r_dst_off, r_offset, r_grant, r_done;
    logic [LEN_WIDTH-1:0] r_rem, w_len;
    logic                 w_pick, w_arb, w_beat, w_m_last, w_fin;
    logic [1:0]           w_onehot, w_p;
    logic [2:0]           w_avail, w_n;
    assign w_pick   = io_bus.req_cmd_valid[~r_last] ? ~r_last : r_last;
    assign w_onehot = w_pick ? 2'b10 : 2'b01;
    assign w_arb    = r_state == IDLE && r_done == 2'b00 && |io_bus.req_cmd_valid;
    assign w_len    = w_pick ? io_bus.req_cmd_len[2*LEN_WIDTH-1:LEN_WIDTH] : io_bus.req_cmd_len[LEN_WIDTH-1:0];
    assign w_beat   = io_bus.ra_tvalid && io_bus.ra_tready;
    assign w_m_last = io_bus.ra_m_tvalid && io_bus.ra_m_tready && io_bus.ra_m_tlast;
    assign w_fin    = r_flag && (r_state == DRAIN || (w_beat && io_bus.ra_tlast));
    // Only the first beat starts mid-word; n is clamped by the bytes still owed.
    assign w_p      = r_first ? r_src_off : 2'd0;
    assign w_avail  = 3'd4 - {1'b0, w_p};
    assign w_n      = r_rem < LEN_WIDTH'(w_avail) ? r_rem[2:0] : w_avail;
    assign io_bus.req_cmd_ready = w_arb ? w_onehot : 2'b00;
    assign io_bus.req_tready    = r_state == XFER ? r_grant & {2{io_bus.ra_tready}} : 2'b00;
    assign io_bus.ra_tvalid     = r_state == XFER && io_bus.req_tvalid[r_sel];
    assign io_bus.ra_tdata      = r_sel ? io_bus.req_tdata[63:32] : io_bus.req_tdata[31:0];
    assign io_bus.ra_tkeep      = r_state == XFER ? (4'hf << (3'd4 - w_n)) >> w_p : 4'h0;
    assign io_bus.ra_tlast      = r_state == XFER && r_rem == LEN_WIDTH'(w_n);
    assign io_bus.ra_init       = r_state == INIT;
    assign io_bus.ra_offset     = r_state == INIT ? r_dst_off : r_offset;
    assign io_bus.done          = r_done;
    assign io_bus.grant         = r_grant;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= IDLE;
        else          r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_arb && w_len != '0 ? INIT : IDLE;
            INIT:    w_next = XFER;
            XFER:    w_next = w_beat && io_bus.ra_tlast ? (r_flag ? IDLE : DRAIN) : XFER;
            default: w_next = r_flag ? IDLE : DRAIN;
        endcase
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_last    <= 1'b1;
            r_sel     <= 1'b0;
            r_first   <= 1'b0;
            r_flag    <= 1'b0;
            r_src_off <= 2'd0;
            r_dst_off <= 2'd0;
            r_offset  <= 2'd0;
            r_grant   <= 2'b00;
            r_done    <= 2'b00;
            r_rem     <= '0;
        end else begin
            r_done <= 2'b00;
            if (w_arb) begin
                r_sel     <= w_pick;
                r_last    <= w_pick;
                r_first   <= 1'b1;
                r_flag    <= 1'b0;
                r_rem     <= w_len;
                r_src_off <= w_pick ? io_bus.req_cmd_src_off[3:2] : io_bus.req_cmd_src_off[1:0];
                r_dst_off <= w_pick ? io_bus.req_cmd_dst_off[3:2] : io_bus.req_cmd_dst_off[1:0];
                r_grant   <= w_len != '0 ? w_onehot : 2'b00;
                r_done    <= w_len == '0 ? w_onehot : 2'b00;
            end
            if (r_state == INIT) r_offset <= r_dst_off;
            if (w_beat) begin
                r_rem   <= r_rem - LEN_WIDTH'(w_n);
                r_first <= 1'b0;
            end
            if ((r_state == XFER || r_state == DRAIN) && w_m_last) r_flag <= 1'b1;
            if (w_fin) begin
                r_done  <= r_grant;
                r_grant <= 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_axis_realign_sched.sv
// tb_axis_realign_sched: directed command table plus hand-written reset and arbitration sequences.
`timescale 1ns/1ps
module tb_axis_realign_sched;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    int n_chk = 0;
    int n_err = 0;
    axis_realign_sched_if #(.LEN_WIDTH(16)) bus();
    axis_realign_sched #(.LEN_WIDTH(16)) dut (.aclk(aclk), .aresetn(aresetn), .io_bus(bus.master));
    always #5 aclk = ~aclk;
    typedef struct {
        int          r;
        logic [1:0]  src;
        logic [1:0]  dst;
        logic [15:0] len;
        int          beats;
        logic [15:0] keeps;
        bit          stall;
    } vec_t;
    vec_t tv[7];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge aclk);
        #1;
    endtask
    task automatic clear_inputs();
        bus.req_cmd_valid = 2'b00;
        bus.req_cmd_src_off = 4'h0;
        bus.req_cmd_dst_off = 4'h0;
        bus.req_cmd_len = '0;
        bus.req_tdata = '0;
        bus.req_tvalid = 2'b00;
        bus.ra_tready = 1'b1;
        bus.ra_m_tvalid = 1'b0;
        bus.ra_m_tready = 1'b0;
        bus.ra_m_tlast = 1'b0;
    endtask
    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cmd_ready"}, bus.req_cmd_ready, 2'b00);
        chk({tag, "_tready"}, bus.req_tready, 2'b00);
        chk({tag, "_init"}, bus.ra_init, 1'b0);
        chk({tag, "_offset"}, bus.ra_offset, 2'd0);
        chk({tag, "_tvalid"}, bus.ra_tvalid, 1'b0);
        chk({tag, "_tlast"}, bus.ra_tlast, 1'b0);
        chk({tag, "_tkeep"}, bus.ra_tkeep, 4'h0);
        chk({tag, "_done"}, bus.done, 2'b00);
        chk({tag, "_grant"}, bus.grant, 2'b00);
    endtask
    task automatic run_cmd(input vec_t v);
        logic [1:0]  oh;
        logic [31:0] d;
        oh = v.r != 0 ? 2'b10 : 2'b01;
        step();
        bus.req_cmd_valid = oh;
        bus.req_cmd_src_off = {v.src, v.src};
        bus.req_cmd_dst_off = {v.dst, v.dst};
        bus.req_cmd_len = {v.len, v.len};
        #1 chk("cmd_ready", bus.req_cmd_ready, oh);
        step();
        bus.req_cmd_valid = 2'b00;
        bus.req_tvalid = oh;
        #1;
        if (v.len == 16'd0) begin
            chk("len0_done", bus.done, oh);
            chk("len0_init", bus.ra_init, 1'b0);
            chk("len0_tvalid", bus.ra_tvalid, 1'b0);
            chk("len0_grant", bus.grant, 2'b00);
            bus.req_tvalid = 2'b00;
            step();
            chk("len0_done_clear", bus.done, 2'b00);
            return;
        end
        chk("init", bus.ra_init, 1'b1);
        chk("init_offset", bus.ra_offset, v.dst);
        chk("init_tvalid", bus.ra_tvalid, 1'b0);
        chk("init_grant", bus.grant, oh);
        for (int k = 0; k < v.beats; k++) begin
            step();
            if (v.stall && k == 1) begin
                bus.req_tvalid = 2'b00;
                #1;
                chk("stall_tvalid", bus.ra_tvalid, 1'b0);
                chk("stall_grant", bus.grant, oh);
                step();
                bus.req_tvalid = oh;
            end
            d = 32'hC0DE0000 + k;
            bus.req_tdata = v.r != 0 ? {d, ~d} : {~d, d};
            #1;
            chk("beat_tvalid", bus.ra_tvalid, 1'b1);
            chk("beat_tkeep", bus.ra_tkeep, v.keeps[15-4*k -: 4]);
            chk("beat_tlast", bus.ra_tlast, k == v.beats - 1);
            chk("beat_tdata", bus.ra_tdata, d);
            chk("beat_tready", bus.req_tready, oh);
        end
        step();
        bus.req_tvalid = 2'b00;
        bus.ra_m_tvalid = 1'b1;
        bus.ra_m_tready = 1'b1;
        bus.ra_m_tlast = 1'b1;
        #1;
        chk("drain_tvalid", bus.ra_tvalid, 1'b0);
        chk("drain_done", bus.done, 2'b00);
        step();
        bus.ra_m_tvalid = 1'b0;
        bus.ra_m_tready = 1'b0;
        bus.ra_m_tlast = 1'b0;
        #1 chk("drain_done_wait", bus.done, 2'b00);
        step();
        chk("done", bus.done, oh);
        chk("done_grant", bus.grant, 2'b00);
        step();
        chk("done_clear", bus.done, 2'b00);
    endtask
    initial begin
        int inits;
        int dones;
        tv[0] = '{0, 2'd0, 2'd0, 16'd8, 2, 16'hFF00, 1'b0};
        tv[1] = '{1, 2'd1, 2'd3, 16'd6, 2, 16'h7E00, 1'b0};
        tv[2] = '{0, 2'd2, 2'd1, 16'd1, 1, 16'h2000, 1'b0};
        tv[3] = '{1, 2'd3, 2'd1, 16'd9, 3, 16'h1FF0, 1'b0};
        tv[4] = '{0, 2'd0, 2'd2, 16'd0, 0, 16'h0000, 1'b0};
        tv[5] = '{1, 2'd2, 2'd0, 16'd2, 1, 16'h3000, 1'b0};
        tv[6] = '{0, 2'd1, 2'd2, 16'd5, 2, 16'h7C00, 1'b1};
        clear_inputs();
        step();
        step();
        check_idle_outputs("reset");
        aresetn = 1'b1;
        for (int i = 0; i < 7; i++) run_cmd(tv[i]);
        step();
        bus.req_cmd_valid = 2'b10;
        bus.req_cmd_src_off = 4'h0;
        bus.req_cmd_dst_off = 4'h0;
        bus.req_cmd_len = {16'd9, 16'd0};
        step();
        bus.req_cmd_valid = 2'b00;
        bus.req_tvalid = 2'b10;
        bus.req_tdata = 64'h1111_2222_3333_4444;
        step();
        chk("rst_beat1_tkeep", bus.ra_tkeep, 4'hF);
        step();
        chk("rst_beat2_tvalid", bus.ra_tvalid, 1'b1);
        chk("rst_beat2_tlast", bus.ra_tlast, 1'b0);
        aresetn = 1'b0;
        #1;
        check_idle_outputs("midrst");
        step();
        chk("midrst_done1", bus.done, 2'b00);
        step();
        chk("midrst_done2", bus.done, 2'b00);
        clear_inputs();
        aresetn = 1'b1;
        bus.req_cmd_valid = 2'b11;
        bus.req_cmd_dst_off = {2'd1, 2'd2};
        bus.req_cmd_len = {16'd4, 16'd4};
        bus.req_tvalid = 2'b11;
        bus.ra_m_tvalid = 1'b1;
        bus.ra_m_tready = 1'b1;
        bus.ra_m_tlast = 1'b1;
        inits = 0;
        dones = 0;
        for (int c = 0; c < 60 && dones < 4; c++) begin
            step();
            if (bus.ra_init) begin
                chk("arb_init_tvalid", bus.ra_tvalid, 1'b0);
                if (inits < 4) begin
                    chk("arb_grant", bus.grant, inits[0] ? 2'b10 : 2'b01);
                    chk("arb_offset", bus.ra_offset, inits[0] ? 2'd1 : 2'd2);
                end
                inits++;
            end
            if (bus.done != 2'b00) begin
                if (dones < 4) chk("arb_done", bus.done, dones[0] ? 2'b10 : 2'b01);
                chk("arb_done_ready", bus.req_cmd_ready, 2'b00);
                dones++;
            end
        end
        clear_inputs();
        chk("arb_inits", inits, 4);
        chk("arb_dones", dones, 4);
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
